gauss_window_ctrl: RTL and testbench
====================================

# gauss_window_ctrl

Frame sequencer for the 3x3 Gaussian FIR path. It tracks the row/column position of every accepted pixel and gates the write strobe into the cascaded line-buffer chain. It flags each cycle in which a complete 3x3 neighbourhood is available and drives the line-buffer `lastout` flush at end of frame to drain the FIFOs. It sits between the pixel source and the two `line_buffer` stages, alongside the kernel MAC.

## Interface
- `IMG_WIDTH`, 4, pixels per row (≥3)
- `IMG_HEIGHT`, 4, rows per frame (≥3)
- `CNT_W`, 9, width of position counters (2^CNT_W > 2*IMG_WIDTH and > IMG_HEIGHT)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to begin a frame; honoured only in IDLE
- `pix_valid`  in  1  upstream pixel strobe
- `lb_wr_en`  out  1  write strobe to first line buffer's `valid_in`
- `lb_flush`  out  1  drives both line buffers' `lastout`
- `win_valid`  out  1  a full 3x3 window is presented to the kernel this cycle
- `win_row`  out  CNT_W  row of window centre
- `win_col`  out  CNT_W  column of window centre
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle end-of-frame pulse
- `drop_err`  out  1  sticky: pixel presented while not accepting

## Operation
- Reset: state IDLE; counters `col`, `row`, `flush_cnt` = 0; all outputs 0.
- States: IDLE, FILL, RUN, FLUSH, DONE.
- IDLE: `start` → FILL; clears `col`, `row`, `drop_err`. A `pix_valid` in the same cycle as `start` is not accepted and does not set `drop_err`. `pix_valid` in IDLE without `start` sets `drop_err`.
- Accept = `pix_valid` && state ∈ {FILL, RUN}. On accept:
  - `col` increments.
  - At `col == IMG_WIDTH-1`, `col` wraps to 0 and `row` increments.
- FILL → RUN when the accept completes row 1, i.e. `row` becomes 2 (two rows stored in the line buffers).
- Window: an accept at position (r, c) with r ≥ 2 and c ≥ 2 produces a window centred at (r-1, c-1).
- Last pixel: an accept at (IMG_HEIGHT-1, IMG_WIDTH-1) → FLUSH with `flush_cnt` = 0.
- FLUSH:
  - `lb_flush` = 1 for exactly 2*IMG_WIDTH cycles, counted by `flush_cnt`.
  - Then → DONE.
  - `pix_valid` in FLUSH is dropped and sets `drop_err`.
- DONE: `frame_done` = 1 for one cycle, then → IDLE.
- `start` outside IDLE is ignored and has no effect on `drop_err`.
- Counters saturate-free: the arithmetic never exceeds IMG_WIDTH-1 / IMG_HEIGHT-1 / 2*IMG_WIDTH-1.

## Timing
- `lb_wr_en` is combinational: `pix_valid` && (state == FILL || state == RUN). Same cycle as the pixel, so the line buffer captures the data with it.
- `win_valid`, `win_row`, `win_col`:
  - Registered, asserted the cycle after the qualifying accept. This matches the line-buffer output alignment.
  - `win_row`/`win_col` hold their last value when `win_valid` = 0.
- `lb_flush`, `busy`, `frame_done` are decoded from the registered state; no combinational path from inputs.
- A flush following the last pixel starts the cycle after that pixel's accept.
- A final-pixel `win_valid` (centre IMG_HEIGHT-2, IMG_WIDTH-2) occurs in the first FLUSH cycle.
- Frame length with continuous `pix_valid`:
  - 1 cycle start→FILL, then IMG_WIDTH*IMG_HEIGHT accept cycles.
  - 2*IMG_WIDTH flush cycles, then 1 DONE cycle.
- Async `rst` mid-frame (any state): immediately IDLE, all outputs 0. `lb_wr_en` drops in the same cycle; the next frame needs a new `start`.
- Gaps in `pix_valid` stall counters only; state and window generation resume on the next accept.

## Test plan
- W=H=4, `start` then 16 back-to-back pixels:
  - `lb_wr_en` high 16 cycles.
  - `win_valid` exactly 4 pulses, centres (1,1),(1,2),(2,1),(2,2).
  - `lb_flush` high 8 cycles, then one `frame_done`.
  - `busy` low afterwards.
- Same frame with `pix_valid` toggling every other cycle → identical `win_valid` count/centres, each one cycle after its accept; `drop_err` = 0.
- `pix_valid` asserted during FLUSH and in IDLE → `lb_wr_en` stays 0 and `drop_err` = 1. A following `start` clears `drop_err` to 0.
- `start` pulsed during RUN → no state change; the frame completes with exactly 4 windows.
- Assert `rst` after pixel 9 (RUN) → all outputs 0 that cycle, state IDLE. A new `start` plus 16 pixels gives the nominal 4 windows and 8 flush cycles.
- W=5, H=3, 15 continuous pixels → 3 windows, centres (1,1),(1,2),(1,3); `lb_flush` 10 cycles.

Source files
------------

// File: rtl/gauss_window_ctrl.sv
// Frame sequencer for the 3x3 Gaussian path: tracks pixel position, gates the
// line-buffer write strobe, flags complete windows and drains the FIFOs at end of frame.
module gauss_window_ctrl #(
   parameter int IMG_WIDTH  = 4,
   parameter int IMG_HEIGHT = 4,
   parameter int CNT_W      = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pix_valid,
   output logic             lb_wr_en,
   output logic             lb_flush,
   output logic             win_valid,
   output logic [CNT_W-1:0] win_row,
   output logic [CNT_W-1:0] win_col,
   output logic             busy,
   output logic             frame_done,
   output logic             drop_err
);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);
   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(IMG_HEIGHT - 1);
   localparam logic [CNT_W-1:0] F_LAST = CNT_W'(2 * IMG_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] col, row, flush_cnt;
   logic             accept;

   assign accept     = pix_valid && (state == S_FILL || state == S_RUN);
   assign lb_wr_en   = accept;
   assign lb_flush   = (state == S_FLUSH);
   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         col       <= '0;
         row       <= '0;
         flush_cnt <= '0;
         win_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
         drop_err  <= 1'b0;
      end else begin
         // Window centre lags the newest pixel by one row and one column.
         win_valid <= 1'b0;
         if (accept && row >= TWO && col >= TWO) begin
            win_valid <= 1'b1;
            win_row   <= row - ONE;
            win_col   <= col - ONE;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_FILL;
                  col      <= '0;
                  row      <= '0;
                  drop_err <= 1'b0;
               end else if (pix_valid) begin
                  drop_err <= 1'b1;
               end
            end
            S_FILL, S_RUN: begin
               if (pix_valid) begin
                  if (col == W_LAST) begin
                     col <= '0;
                     if (row == H_LAST) begin
                        state     <= S_FLUSH;
                        flush_cnt <= '0;
                     end else begin
                        row <= row + ONE;
                        if (state == S_FILL && row == ONE) state <= S_RUN;
                     end
                  end else begin
                     col <= col + ONE;
                  end
               end
            end
            S_FLUSH: begin
               if (pix_valid) drop_err <= 1'b1;
               if (flush_cnt == F_LAST) state <= S_DONE;
               else flush_cnt <= flush_cnt + ONE;
            end
            S_DONE: begin
               if (pix_valid) drop_err <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gauss_window_ctrl.sv
// Randomized bench for gauss_window_ctrl: two geometries (4x4 and 5x3) checked
// cycle by cycle against a pixel-index based frame model.
module tb_gauss_window_ctrl;
   localparam int CW = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start_a, pv_a, start_b, pv_b;
   logic wr_a, fl_a, wv_a, busy_a, fd_a, de_a;
   logic wr_b, fl_b, wv_b, busy_b, fd_b, de_b;
   logic [CW-1:0] wr_row_a, wc_a, wr_row_b, wc_b;

   gauss_window_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .CNT_W(CW)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .pix_valid(pv_a), .lb_wr_en(wr_a),
      .lb_flush(fl_a), .win_valid(wv_a), .win_row(wr_row_a), .win_col(wc_a),
      .busy(busy_a), .frame_done(fd_a), .drop_err(de_a));

   gauss_window_ctrl #(.IMG_WIDTH(5), .IMG_HEIGHT(3), .CNT_W(CW)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .pix_valid(pv_b), .lb_wr_en(wr_b),
      .lb_flush(fl_b), .win_valid(wv_b), .win_row(wr_row_b), .win_col(wc_b),
      .busy(busy_b), .frame_done(fd_b), .drop_err(de_b));

   int sel;
   logic o_wr, o_fl, o_wv, o_busy, o_fd, o_de;
   logic [CW-1:0] o_row, o_col;
   always_comb begin
      o_wr = sel ? wr_b : wr_a;       o_fl = sel ? fl_b : fl_a;
      o_wv = sel ? wv_b : wv_a;       o_busy = sel ? busy_b : busy_a;
      o_fd = sel ? fd_b : fd_a;       o_de = sel ? de_b : de_a;
      o_row = sel ? wr_row_b : wr_row_a;
      o_col = sel ? wc_b : wc_a;
   end

   int n_chk = 0, n_fail = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
      end
   endtask

   // Model: mode 0 idle, 1 accepting, 2 flushing, 3 done. Position derives from pixel index.
   int W, H;
   int m_mode, m_n, m_fl, e_wr, e_wc;
   bit m_drop, e_wv, m_counted;
   int f_win, f_fl, f_wr;

   task automatic model_reset();
      m_mode = 0; m_n = 0; m_fl = 0; m_drop = 0;
      e_wv = 0; e_wr = 0; e_wc = 0; m_counted = 0;
   endtask

   task automatic model_update(input bit st, input bit pv);
      int r, c;
      e_wv = 0;
      if (pv && m_mode == 1) begin
         r = m_n / W; c = m_n % W;
         if (r >= 2 && c >= 2) begin e_wv = 1; e_wr = r - 1; e_wc = c - 1; end
      end
      case (m_mode)
         0: if (st) begin
               m_mode = 1; m_n = 0; m_drop = 0;
               m_counted = 1; f_win = 0; f_fl = 0; f_wr = 0;
            end else if (pv) m_drop = 1;
         1: if (pv) begin
               m_n++;
               if (m_n == W * H) begin m_mode = 2; m_fl = 0; end
            end
         2: begin
               if (pv) m_drop = 1;
               m_fl++;
               if (m_fl == 2 * W) m_mode = 3;
            end
         default: begin
               if (pv) m_drop = 1;
               m_mode = 0;
            end
      endcase
   endtask

   task automatic drive(input bit st, input bit pv);
      start_a = (sel == 0) ? st : 1'b0;  pv_a = (sel == 0) ? pv : 1'b0;
      start_b = (sel == 1) ? st : 1'b0;  pv_b = (sel == 1) ? pv : 1'b0;
   endtask

   // p_pv < 0 alternates pix_valid every cycle; otherwise percentage chances.
   task automatic step(input int p_pv, input int p_st);
      bit st, pv;
      @(negedge clk);
      cyc++;
      chk("busy", o_busy, m_mode != 0);
      chk("lb_flush", o_fl, m_mode == 2);
      chk("frame_done", o_fd, m_mode == 3);
      chk("drop_err", o_de, m_drop);
      chk("win_valid", o_wv, e_wv);
      chk("win_row", o_row, e_wr);
      chk("win_col", o_col, e_wc);
      if (o_wv) f_win++;
      if (o_fl) f_fl++;
      if (m_mode == 3 && m_counted) begin
         chk("frame_windows", f_win, (W - 2) * (H - 2));
         chk("frame_flush_cycles", f_fl, 2 * W);
         chk("frame_wr_cycles", f_wr, W * H);
         m_counted = 0;
      end
      pv = (p_pv < 0) ? cyc[0] : ($urandom_range(0, 99) < p_pv);
      st = (m_mode == 0) ? ($urandom_range(0, 99) < p_st) : ($urandom_range(0, 99) < 5);
      drive(st, pv);
      #1;
      chk("lb_wr_en", o_wr, pv && m_mode == 1);
      if (o_wr) f_wr++;
      model_update(st, pv);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_wr"}, o_wr, 0);     chk({tag, "_flush"}, o_fl, 0);
      chk({tag, "_wv"}, o_wv, 0);     chk({tag, "_row"}, o_row, 0);
      chk({tag, "_col"}, o_col, 0);   chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_fd, 0);   chk({tag, "_drop"}, o_de, 0);
   endtask

   task automatic mid_frame_reset();
      bit hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         step(100, 100);
         if (m_mode == 1 && m_n == 9) hit = 1;
      end
      chk("reach_pixel9", hit, 1);
      @(negedge clk);
      drive(1'b0, 1'b1);
      #1;
      chk("pre_rst_wr", o_wr, hit);
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      drive(1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sel = 0;
      start_a = 0; pv_a = 0; start_b = 0; pv_b = 0;
      f_win = 0; f_fl = 0; f_wr = 0;
      #1;
      sel = 0; #1; check_all_zero("reset_a");
      sel = 1; #1; check_all_zero("reset_b");
      @(negedge clk);
      rst = 1'b0;

      sel = 0; W = 4; H = 4; model_reset();
      for (int i = 0; i < 40; i++)  step(100, 100);
      for (int i = 0; i < 80; i++)  step(-1, 100);
      for (int i = 0; i < 500; i++) step(35, 20);
      mid_frame_reset();
      for (int i = 0; i < 60; i++)  step(100, 100);
      for (int i = 0; i < 300; i++) step(70, 30);

      drive(1'b0, 1'b0);
      sel = 1; W = 5; H = 3; model_reset();
      rst = 1'b1; #1; rst = 1'b0;
      for (int i = 0; i < 40; i++)  step(100, 100);
      for (int i = 0; i < 400; i++) step(50, 25);
      mid_frame_reset();
      for (int i = 0; i < 60; i++)  step(100, 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
